// File: rtl/issue_rat_pkg.sv
// issue_rat_pkg
//   Shared rename-stage definitions used by issue_rat_freelist, the rename RAT
//   and issue_rat_redeem_queue.
//   PRF_WIDTH : physical register index width
//   FGR_WIDTH : number of physical registers tracked by the freelist (2**PRF_WIDTH)
//   prf_idx_t : physical register index
//   ZERO_PRF  : hard-wired zero mapping, never recycled
package issue_rat_pkg;

    localparam int PRF_WIDTH = 6;
    localparam int FGR_WIDTH = 1 << PRF_WIDTH;

    typedef logic [PRF_WIDTH-1:0] prf_idx_t;

    localparam prf_idx_t ZERO_PRF = '0;

endpackage

// File: rtl/issue_rat_prf_bitmap.sv
// issue_rat_prf_bitmap
//   One presence bit per physical register. Two set ports, one clear port and
//   two combinational test ports reading the registered vector.
//   clk, reset          : clock, synchronous active-high reset (clears all bits)
//   set0_en/set0_idx    : mark a PRF present
//   set1_en/set1_idx    : mark a second PRF present
//   clr_en/clr_idx      : mark a PRF absent (a same-cycle set of that PRF wins)
//   test0_idx/test0_hit : presence lookup, lane 0
//   test1_idx/test1_hit : presence lookup, lane 1
module issue_rat_prf_bitmap #(
    parameter int P_PRF_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set0_en,
    input  logic [P_PRF_WIDTH-1:0] set0_idx,
    input  logic                   set1_en,
    input  logic [P_PRF_WIDTH-1:0] set1_idx,
    input  logic                   clr_en,
    input  logic [P_PRF_WIDTH-1:0] clr_idx,
    input  logic [P_PRF_WIDTH-1:0] test0_idx,
    input  logic [P_PRF_WIDTH-1:0] test1_idx,
    output logic                   test0_hit,
    output logic                   test1_hit
);

    localparam int N_BITS = 1 << P_PRF_WIDTH;

    logic [N_BITS-1:0] bits_q;
    logic [N_BITS-1:0] bits_d;

    // NOTE: every variable written here gets a default first, otherwise the
    // conditional updates below would infer latches.
    always_comb begin
        bits_d = bits_q;
        // Clear before set: a PRF popped and re-pushed in one cycle stays present.
        if (clr_en)  bits_d[clr_idx]  = 1'b0;
        if (set0_en) bits_d[set0_idx] = 1'b1;
        if (set1_en) bits_d[set1_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) bits_q <= '0;
        else       bits_q <= bits_d;
    end

    assign test0_hit = bits_q[test0_idx];
    assign test1_hit = bits_q[test1_idx];

endmodule

// File: rtl/issue_rat_redeem_queue.sv
// issue_rat_redeem_queue
//   Buffers PRFs released at ROB retirement (up to two per cycle) and drains
//   them one per cycle into the RAT freelist redeem port.
//   clk, reset                       : clock, synchronous active-high reset
//   i_retire_prf0/valid0             : released PRF, lane 0 (older)
//   i_retire_prf1/valid1             : released PRF, lane 1 (younger)
//   o_retire_ready                   : at least two free entries
//   o_redeemed_prf/valid, i_redeemed_ready : head entry toward the freelist
//   o_count                          : registered occupancy
//   o_dup_error                      : sticky, a PRF was pushed while already queued
module issue_rat_redeem_queue
    import issue_rat_pkg::*;
#(
    parameter int P_PRF_WIDTH = PRF_WIDTH,
    parameter int P_DEPTH     = 16,
    parameter bit P_SKIP_ZERO = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [P_PRF_WIDTH-1:0]       i_retire_prf0,
    input  logic                         i_retire_valid0,
    input  logic [P_PRF_WIDTH-1:0]       i_retire_prf1,
    input  logic                         i_retire_valid1,
    output logic                         o_retire_ready,
    output logic [P_PRF_WIDTH-1:0]       o_redeemed_prf,
    output logic                         o_redeemed_valid,
    input  logic                         i_redeemed_ready,
    output logic [$clog2(P_DEPTH):0]     o_count,
    output logic                         o_dup_error
);

    localparam int PTR_W = $clog2(P_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [P_PRF_WIDTH-1:0] mem [P_DEPTH];
    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [PTR_W-1:0]       tail_plus1;
    logic [CNT_W-1:0]       count_q;
    logic                   dup_q;

    logic acc0;
    logic acc1;
    logic pop;
    logic hit0;
    logic hit1;
    logic dup_now;

    // Ready looks only at the registered count; a same-cycle pop is not
    // credited, which keeps i_redeemed_ready off the retire path.
    assign o_retire_ready   = (count_q <= CNT_W'(P_DEPTH - 2));
    assign o_redeemed_valid = (count_q != '0);
    assign o_redeemed_prf   = o_redeemed_valid ? mem[head_q] : '0;
    assign o_count          = count_q;
    assign o_dup_error      = dup_q;

    assign acc0 = i_retire_valid0 && o_retire_ready && !(P_SKIP_ZERO && i_retire_prf0 == '0);
    assign acc1 = i_retire_valid1 && o_retire_ready && !(P_SKIP_ZERO && i_retire_prf1 == '0);
    assign pop  = o_redeemed_valid && i_redeemed_ready;

    // Power-of-two depth: pointer arithmetic wraps by truncation.
    assign tail_plus1 = tail_q + 1'b1;

    issue_rat_prf_bitmap #(
        .P_PRF_WIDTH (P_PRF_WIDTH)
    ) u_bitmap (
        .clk       (clk),
        .reset     (reset),
        .set0_en   (acc0),
        .set0_idx  (i_retire_prf0),
        .set1_en   (acc1),
        .set1_idx  (i_retire_prf1),
        .clr_en    (pop),
        .clr_idx   (o_redeemed_prf),
        .test0_idx (i_retire_prf0),
        .test1_idx (i_retire_prf1),
        .test0_hit (hit0),
        .test1_hit (hit1)
    );

    assign dup_now = (acc0 && hit0) || (acc1 && hit1) ||
                     (acc0 && acc1 && (i_retire_prf0 == i_retire_prf1));

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dup_q   <= 1'b0;
        end else begin
            if (pop) head_q <= head_q + 1'b1;
            tail_q  <= tail_q + PTR_W'(acc0) + PTR_W'(acc1);
            count_q <= count_q + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(pop);
            if (dup_now) dup_q <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by count_q and
    // the output is forced to zero when empty, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (acc0) mem[tail_q] <= i_retire_prf0;
        if (acc1) mem[acc0 ? tail_plus1 : tail_q] <= i_retire_prf1;
    end

    // Upstream must never present a retirement while the queue is not ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (o_retire_ready || !(i_retire_valid0 || i_retire_valid1));
        end
    end

endmodule

// File: tb/tb_issue_rat_redeem_queue.sv
module tb_issue_rat_redeem_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] i_retire_prf0;
    logic       i_retire_valid0;
    logic [5:0] i_retire_prf1;
    logic       i_retire_valid1;
    logic       o_retire_ready;
    logic [5:0] o_redeemed_prf;
    logic       o_redeemed_valid;
    logic       i_redeemed_ready;
    logic [4:0] o_count;
    logic       o_dup_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    issue_rat_redeem_queue dut (
        .clk              (clk),
        .reset            (reset),
        .i_retire_prf0    (i_retire_prf0),
        .i_retire_valid0  (i_retire_valid0),
        .i_retire_prf1    (i_retire_prf1),
        .i_retire_valid1  (i_retire_valid1),
        .o_retire_ready   (o_retire_ready),
        .o_redeemed_prf   (o_redeemed_prf),
        .o_redeemed_valid (o_redeemed_valid),
        .i_redeemed_ready (i_redeemed_ready),
        .o_count          (o_count),
        .o_dup_error      (o_dup_error)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [5:0] p0,
                         input logic v1, input logic [5:0] p1, input logic rdy);
        i_retire_valid0  = v0;
        i_retire_prf0    = p0;
        i_retire_valid1  = v1;
        i_retire_prf1    = p1;
        i_redeemed_ready = rdy;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 6'd0, 1'b0, 6'd0, rdy);
    endtask

    task automatic check_out(input string tag, input int valid, input int prf, input int cnt);
        check({tag, ".valid"}, int'(o_redeemed_valid), valid);
        check({tag, ".prf"},   int'(o_redeemed_prf),   prf);
        check({tag, ".count"}, int'(o_count),          cnt);
    endtask

    initial begin
        reset = 1'b1;
        idle(1'b0);
        step();
        step();
        reset = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 5; i++) begin
            step();
            check_out("t1", 0, 0, 0);
            check("t1.ready", int'(o_retire_ready), 1);
            check("t1.dup",   int'(o_dup_error),    0);
        end

        // 2: two-lane push, drained in order with one-cycle latency
        drive(1'b1, 6'd5, 1'b1, 6'd9, 1'b1);
        step();
        check_out("t2.a", 1, 5, 2);
        idle(1'b1);
        step();
        check_out("t2.b", 1, 9, 1);
        step();
        check_out("t2.c", 0, 0, 0);

        // 3: fill to 14 with freelist stalled, then drain in order
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 6'(2 * k + 1), 1'b1, 6'(2 * k + 2), 1'b0);
            step();
        end
        idle(1'b0);
        check_out("t3.fill", 1, 1, 14);
        check("t3.ready14", int'(o_retire_ready), 1);
        idle(1'b1);
        for (int k = 1; k <= 14; k++) begin
            check("t3.order", int'(o_redeemed_prf), k);
            step();
        end
        check_out("t3.empty", 0, 0, 0);

        // 3b: second fill across the pointer wrap, reaching full
        for (int k = 0; k < 8; k++) begin
            check("t3b.ready", int'(o_retire_ready), 1);
            drive(1'b1, 6'(20 + 2 * k), 1'b1, 6'(21 + 2 * k), 1'b0);
            step();
        end
        idle(1'b0);
        check_out("t3b.full", 1, 20, 16);
        check("t3b.ready_full", int'(o_retire_ready), 0);
        idle(1'b1);
        for (int k = 0; k < 16; k++) begin
            check("t3b.order", int'(o_redeemed_prf), 20 + k);
            step();
        end
        check_out("t3b.empty", 0, 0, 0);
        check("t3b.dup", int'(o_dup_error), 0);

        // 4: PRF 0 is never enqueued; 7 was popped earlier so no duplicate
        drive(1'b1, 6'd0, 1'b1, 6'd7, 1'b0);
        step();
        check_out("t4", 1, 7, 1);
        check("t4.dup", int'(o_dup_error), 0);
        idle(1'b1);
        step();
        check_out("t4.empty", 0, 0, 0);

        // 5: count 3, push 2 and pop 1 in the same cycle
        drive(1'b1, 6'd40, 1'b1, 6'd41, 1'b0);
        step();
        drive(1'b1, 6'd42, 1'b0, 6'd0, 1'b0);
        step();
        check_out("t5.pre", 1, 40, 3);
        drive(1'b1, 6'd43, 1'b1, 6'd44, 1'b1);
        step();
        check_out("t5.post", 1, 41, 4);
        idle(1'b1);
        for (int k = 41; k <= 44; k++) begin
            check("t5.order", int'(o_redeemed_prf), k);
            step();
        end
        check_out("t5.empty", 0, 0, 0);

        // 6: duplicate push is sticky, reset clears everything
        drive(1'b1, 6'd12, 1'b0, 6'd0, 1'b0);
        step();
        check("t6.dup_first", int'(o_dup_error), 0);
        drive(1'b1, 6'd12, 1'b0, 6'd0, 1'b0);
        step();
        check("t6.dup_set", int'(o_dup_error), 1);
        check("t6.count", int'(o_count), 2);
        idle(1'b0);
        step();
        check("t6.dup_sticky", int'(o_dup_error), 1);
        reset = 1'b1;
        drive(1'b1, 6'd50, 1'b0, 6'd0, 1'b1);
        step();
        reset = 1'b0;
        idle(1'b0);
        check_out("t6.reset", 0, 0, 0);
        check("t6.reset_dup",   int'(o_dup_error),    0);
        check("t6.reset_ready", int'(o_retire_ready), 1);
        drive(1'b1, 6'd12, 1'b0, 6'd0, 1'b0);
        step();
        check_out("t6.after", 1, 12, 1);
        check("t6.bitmap_cleared", int'(o_dup_error), 0);
        drive(1'b1, 6'd30, 1'b1, 6'd30, 1'b0);
        step();
        check("t6.same_lane_dup", int'(o_dup_error), 1);
        check("t6.same_lane_count", int'(o_count), 3);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
